// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates one data memory between a CPU port and a DMA port, with halt capture and run counters.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_req/we/addr/wd, cpu_rd   CPU byte-addressed access; read data passes straight through from memory
//   cpu_stall                    CPU must hold its access this cycle
//   dma_req/we/addr/wd           DMA word-addressed access
//   dma_gnt                      DMA access applied to memory this cycle
//   dma_rvalid, dma_rdata        registered DMA read return
//   mem_a/wd/we, mem_rd          memory port (asynchronous read)
//   halted, halt_data            sticky halt flag and data of the halting write
//   cycle_cnt, stall_cnt         run-time cycle and CPU stall counters, frozen at halt
module dmem_arbiter #(
    parameter int          DATA_W     = 32,
    parameter int          MA_W       = 16,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] HALT_ADDR  = 32'h00007fff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [MA_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [MA_W-1:0]   mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              halted,
    output logic [DATA_W-1:0] halt_data,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       stall_cnt
);
    typedef enum logic {RUN, HALT} state_t;
    localparam int WC_W = $clog2(STARVE_MAX + 1);
    state_t state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic starve, cpu_gnt, halt_wr;
    assign cpu_rd = mem_rd;
    assign halted = state == HALT;
    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        halt_wr   = 1'b0;
        starve    = dma_req && wait_cnt == WC_W'(STARVE_MAX);
        // rst gates every grant so an access in flight is dropped immediately
        if (!rst && state == HALT) begin
            dma_gnt   = dma_req;
            cpu_stall = 1'b1;
        end else if (!rst) begin
            cpu_gnt   = cpu_req && !starve;
            dma_gnt   = dma_req && (starve || !cpu_req);
            cpu_stall = cpu_req && starve;
            halt_wr   = cpu_gnt && cpu_we && cpu_addr == DATA_W'(HALT_ADDR);
            state_nxt = halt_wr ? HALT : RUN;
        end
        mem_a    = cpu_gnt ? cpu_addr[MA_W+1:2] : dma_gnt ? dma_addr : '0;
        mem_wd   = cpu_gnt ? cpu_wd : dma_gnt ? dma_wd : '0;
        mem_we   = cpu_gnt ? cpu_we && !halt_wr : dma_gnt && dma_we;
        wait_nxt = (!dma_req || dma_gnt) ? '0 : starve ? wait_cnt : wait_cnt + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            halt_data  <= '0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            dma_rvalid <= dma_gnt && !dma_we;
            if (halt_wr) halt_data <= cpu_wd;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rd;
            if (state == RUN) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                stall_cnt <= stall_cnt + {31'd0, cpu_stall};
            end
        end
    end
endmodule
